// File: rtl/program_loader.sv
// program_loader
//   Clears a program memory to HALT_WORD, then streams instructions into it
//   from a valid/ready source while holding the core in reset. Once the last
//   word lands it releases the core. A stream that would run past the end of
//   memory parks in an error state with the core held in reset.
//
// Ports
//   clock, reset         single clock, asynchronous active-high reset
//   start                begin a clear-and-load (honoured in IDLE, RUN, ERROR)
//   load_valid/ready     instruction stream handshake, load_last marks the end
//   load_data            instruction word
//   mem_write_enable     program-memory write strobe (one cycle per write)
//   mem_address          program-memory write address
//   mem_write_data       program-memory write data
//   core_reset           active-high reset for the core, low only in RUN
//   busy, done, overflow status: clearing/loading, running, stream too long
//   loaded_count         words accepted in the current load
module program_loader #(
  parameter int INST_WIDTH = 16,
  parameter int MEM_DEPTH  = 256,
  parameter logic [INST_WIDTH-1:0] HALT_WORD = {INST_WIDTH{1'b1}},
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [INST_WIDTH-1:0] mem_write_data,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   loaded_count
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_CNT  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                state_reg;
  // Number of clear writes already issued; one bit wider than an address so
  // that "all MEM_DEPTH written" is distinguishable from address 0.
  logic [ADDR_WIDTH:0]   clear_cnt_reg;

  // Combinational from state only, so a source can see it in the same cycle.
  assign load_ready = (state_reg == LOAD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      clear_cnt_reg    <= '0;
      loaded_count     <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      core_reset       <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      case (state_reg)
        IDLE, RUN, ERROR: begin
          if (start) begin
            // Address 0 is written on the same edge that samples start, so the
            // first clear write is visible in the very next cycle.
            state_reg        <= CLEAR;
            mem_write_enable <= 1'b1;
            mem_address      <= '0;
            mem_write_data   <= HALT_WORD;
            clear_cnt_reg    <= CNT_ONE;
            loaded_count     <= '0;
            core_reset       <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            overflow         <= 1'b0;
          end
        end

        CLEAR: begin
          if (clear_cnt_reg == DEPTH_CNT) begin
            state_reg <= LOAD;
          end else begin
            mem_write_enable <= 1'b1;
            mem_address      <= clear_cnt_reg[ADDR_WIDTH-1:0];
            mem_write_data   <= HALT_WORD;
            clear_cnt_reg    <= clear_cnt_reg + CNT_ONE;
          end
        end

        LOAD: begin
          if (load_valid) begin
            mem_write_enable <= 1'b1;
            mem_address      <= loaded_count[ADDR_WIDTH-1:0];
            mem_write_data   <= load_data;
            loaded_count     <= loaded_count + CNT_ONE;
            // load_last is checked first so a stream that exactly fills the
            // memory finishes cleanly instead of flagging overflow.
            if (load_last) begin
              state_reg  <= RUN;
              core_reset <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (loaded_count == LAST_CNT) begin
              state_reg <= ERROR;
              busy      <= 1'b0;
              overflow  <= 1'b1;
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          core_reset <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          overflow   <= 1'b0;
        end
      endcase
    end
  end

endmodule
